// File: rtl/aes_stream_feeder.sv
// Packs 32-bit words into 128-bit blocks for the AES_CO encrypt core (ECB or CBC) and serialises results out.
// Block issued 1 cycle after the 4th word; s_ready only in COLLECT; m_data/m_valid held while m_ready is low.
module aes_stream_feeder #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [127:0]     key_in,
  input  logic [127:0]     iv_in,
  input  logic             cbc_en,
  input  logic             key_load,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     core_key,
  output logic [127:0]     core_din,
  output logic             core_krdy,
  output logic             core_drdy,
  output logic             core_en,
  output logic             core_rst_n,
  input  logic [127:0]     core_dout,
  input  logic             core_bsy,
  input  logic             core_dvld,
  output logic             key_valid,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, KEYLD, KWAIT, COLLECT, ISSUE, WAIT, DRAIN} state_t;

  state_t          state, state_n;
  logic [1:0]      wcnt, ocnt;
  logic [95:0]     blk;
  logic [95:0]     out_rem;
  logic [127:0]    chain;
  logic            cbc_mode;
  logic            kw_seen;
  logic [WD_W-1:0] wdog;
  logic            key_take, s_acc, m_acc, wd_expired;

  // A new key is only taken between blocks, so a partial block is never lost.
  assign key_take   = key_load && ((state == IDLE) || ((state == COLLECT) && (wcnt == 2'd0)));
  assign s_ready    = (state == COLLECT) && !key_take;
  assign s_acc      = s_valid && s_ready;
  assign m_acc      = (state == DRAIN) && m_valid && m_ready;
  assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (key_take) state_n = KEYLD;
      KEYLD:   state_n = KWAIT;
      KWAIT:   if (kw_seen && !core_bsy) state_n = COLLECT;
      COLLECT: begin
        if (key_take)                       state_n = KEYLD;
        else if (s_acc && (wcnt == 2'd3))   state_n = ISSUE;
      end
      ISSUE:   if (!core_bsy) state_n = WAIT;
      WAIT: begin
        if (core_dvld)       state_n = DRAIN;
        else if (wd_expired) state_n = COLLECT;
      end
      DRAIN:   if (m_acc && (ocnt == 2'd3)) state_n = COLLECT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt       <= '0;
      ocnt       <= '0;
      blk        <= '0;
      out_rem    <= '0;
      chain      <= '0;
      cbc_mode   <= 1'b0;
      kw_seen    <= 1'b0;
      wdog       <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      core_key   <= '0;
      core_din   <= '0;
      core_krdy  <= 1'b0;
      core_drdy  <= 1'b0;
      core_en    <= 1'b0;
      core_rst_n <= 1'b0;
      key_valid  <= 1'b0;
      err        <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      // Strobes are registered from the next state so they line up with the state they belong to.
      core_rst_n <= 1'b1;
      core_en    <= (state_n != IDLE);
      core_krdy  <= (state_n == KEYLD);
      core_drdy  <= (state == ISSUE) && (state_n == WAIT);
      m_valid    <= (state_n == DRAIN);

      if (key_take) begin
        core_key  <= key_in;
        chain     <= iv_in;
        cbc_mode  <= cbc_en;
        err       <= 1'b0;
        key_valid <= 1'b0;
        kw_seen   <= 1'b0;
      end

      if (state == KWAIT) begin
        kw_seen <= 1'b1;
        if (state_n == COLLECT) key_valid <= 1'b1;
      end

      if (s_acc) begin
        blk  <= {blk[63:0], s_data};
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3) core_din <= {blk, s_data} ^ (cbc_mode ? chain : '0);
      end

      if (state == ISSUE) wdog <= '0;

      if (state == WAIT) begin
        wdog <= wdog + WD_W'(1);
        if (core_dvld) begin
          m_data  <= core_dout[127:96];
          out_rem <= core_dout[95:0];
          ocnt    <= '0;
          blk_cnt <= blk_cnt + CNT_W'(1);
          if (cbc_mode) chain <= core_dout;
        end else if (wd_expired) begin
          // Abandon the block; chain is left as it was so the stream can resume.
          err  <= 1'b1;
          wcnt <= '0;
        end
      end

      if (m_acc) begin
        m_data  <= out_rem[95:64];
        out_rem <= {out_rem[63:0], 32'h0};
        ocnt    <= ocnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Bench for aes_stream_feeder: behavioural AES_CO stub, table of known-answer blocks, directed corner sequences.
module tb_aes_stream_feeder;

  localparam int TO = 24;
  localparam int CW = 16;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [127:0]   key_in = '0, iv_in = '0;
  logic           cbc_en = 1'b0, key_load = 1'b0;
  logic [31:0]    s_data = '0;
  logic           s_valid = 1'b0, s_ready;
  logic [31:0]    m_data;
  logic           m_valid, m_ready = 1'b0;
  logic [127:0]   core_key, core_din;
  logic           core_krdy, core_drdy, core_en, core_rst_n;
  logic [127:0]   core_dout = '0;
  logic           core_bsy = 1'b0, core_dvld = 1'b0;
  logic           key_valid, err;
  logic [CW-1:0]  blk_cnt;

  aes_stream_feeder #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .key_in(key_in), .iv_in(iv_in), .cbc_en(cbc_en), .key_load(key_load),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .core_key(core_key), .core_din(core_din), .core_krdy(core_krdy), .core_drdy(core_drdy),
    .core_en(core_en), .core_rst_n(core_rst_n), .core_dout(core_dout), .core_bsy(core_bsy),
    .core_dvld(core_dvld), .key_valid(key_valid), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- AES-128 reference model ----------------
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] r, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      r = 8'h00;
      if (v != 0) begin
        r = x;
        for (int i = 0; i < 253; i++) r = gmul(r, x);
      end
      sbox[v] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [127:0] st, t;
    logic [7:0]   rc, a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      t = '0;
      for (int i = 0; i < 16; i++) begin
        int rr, c;
        rr = i % 4; c = i / 4;
        t[127-8*i -: 8] = sbox[st[127-8*(rr+4*((c+rr)%4)) -: 8]];
      end
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          t[127-32*c -: 32] = {gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
                               gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
        end
      end
      st = t ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // ---------------- stub AES_CO core ----------------
  logic         stub_dead = 1'b0;
  int           stub_lat  = 3;
  logic         pend      = 1'b0;
  int           pend_cnt  = 0;
  logic [127:0] pend_din  = '0;
  logic [127:0] stub_key  = '0;

  always @(negedge CLK) begin
    core_dvld = 1'b0;
    if (core_krdy) stub_key = core_key;
    if (pend) begin
      if (pend_cnt == 0) begin
        core_dvld = 1'b1;
        core_dout = aes_enc(stub_key, pend_din);
        pend      = 1'b0;
      end else pend_cnt--;
    end
    if (core_drdy && !stub_dead) begin
      pend = 1'b1; pend_cnt = stub_lat; pend_din = core_din;
    end
  end

  // ---------------- protocol monitor ----------------
  int          wsl        = 0;
  logic        drdy_early = 1'b0;
  logic        stab_err   = 1'b0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge CLK) begin
    if (core_drdy) begin
      if (wsl != 4) drdy_early = 1'b1;
      wsl = 0;
    end
    if (s_valid && s_ready) wsl++;
    if (pv && !pr && (!m_valid || (m_data !== pd))) stab_err = 1'b1;
    pv = m_valid; pr = m_ready; pd = m_data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic key_ld(input logic [127:0] k, input logic [127:0] iv, input logic c,
                        input logic with_word, input string nm);
    int kr;
    bit ok;
    key_in = k; iv_in = iv; cbc_en = c; key_load = 1'b1;
    if (with_word) begin
      s_data = 32'hdeadbeef; s_valid = 1'b1;
      #1;
      chk({nm, " s_ready low on key_load"}, 128'(s_ready), 128'd0);
    end
    tick();
    key_load = 1'b0; s_valid = 1'b0;
    kr = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (core_krdy) kr++;
      if (key_valid && s_ready) begin ok = 1'b1; break; end
      tick();
    end
    chk({nm, " krdy pulses"}, 128'(kr), 128'd1);
    chk({nm, " key ready"}, 128'(ok), 128'd1);
    chk({nm, " core_key"}, core_key, k);
  endtask

  task automatic send_word(input logic [31:0] w, input string nm);
    bit ok;
    ok = 1'b0; s_data = w; s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ok = s_ready;
      tick();
      if (ok) break;
    end
    s_valid = 1'b0;
    chk({nm, " word accepted"}, 128'(ok), 128'd1);
  endtask

  task automatic send_blk(input logic [127:0] pt, input int gap, input string nm);
    for (int i = 0; i < 4; i++) begin
      send_word(pt[127-32*i -: 32], nm);
      repeat (gap) tick();
    end
  endtask

  task automatic recv_blk(input int pat, output logic [127:0] got, output bit ok);
    int n;
    n = 0; got = '0;
    for (int c = 0; c < 300 && n < 4; c++) begin
      m_ready = (pat == 0) ? 1'b1 : (c % 3 == 0);
      if (m_valid && m_ready) begin
        got[127-32*n -: 32] = m_data;
        n++;
      end
      tick();
    end
    m_ready = 1'b0;
    ok = (n == 4);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0]  key;
    logic [127:0]  iv;
    logic          cbc;
    logic          load;
    logic          model;
    logic [127:0]  pt;
    logic [127:0]  ct;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL global_timeout: run did not finish, limit 1000000 time units");
    $fatal(1);
  end

  initial begin
    logic [127:0] got, exp;
    bit           ok;
    int           k, kr;
    logic         flag;

    tbl[0] = '{FK, 128'h0, 1'b0, 1'b1, 1'b0, P0, C0, 16'd1};
    tbl[1] = '{KB, 128'h0, 1'b0, 1'b1, 1'b0, PB, 128'h3925841d02dc09fbdc118597196a0b32, 16'd2};
    tbl[2] = '{KB, 128'h0, 1'b0, 1'b0, 1'b0, P1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 16'd3};
    tbl[3] = '{KB, 128'h0, 1'b0, 1'b0, 1'b0, P2, 128'hf5d3d58503b9699de785895a96fdbaaf, 16'd4};
    tbl[4] = '{KB, FK,     1'b1, 1'b1, 1'b0, P1, 128'h7649abac8119b246cee98e9b12e9197d, 16'd5};
    tbl[5] = '{KB, FK,     1'b1, 1'b0, 1'b0, P2, 128'h5086cb9b507219ee95db113a917678b2, 16'd6};
    tbl[6] = '{FK, 128'h0, 1'b1, 1'b1, 1'b0, P0, C0, 16'd7};
    tbl[7] = '{FK, 128'h0, 1'b1, 1'b0, 1'b1, P0, 128'h0, 16'd8};

    init_sbox();

    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst s_ready",   128'(s_ready),   128'd0);
    chk("rst m_valid",   128'(m_valid),   128'd0);
    chk("rst key_valid", 128'(key_valid), 128'd0);
    chk("rst blk_cnt",   128'(blk_cnt),   128'd0);
    chk("rst core_en",   128'(core_en),   128'd0);
    chk("rst core_rst_n", 128'(core_rst_n), 128'd0);
    tick();
    chk("idle core_rst_n", 128'(core_rst_n), 128'd1);
    chk("idle core_en",    128'(core_en),    128'd0);

    // Known-answer table, ECB and CBC
    for (int r = 0; r < 8; r++) begin
      string nm;
      nm = $sformatf("vec%0d", r);
      if (tbl[r].load) key_ld(tbl[r].key, tbl[r].iv, tbl[r].cbc, 1'b0, nm);
      send_blk(tbl[r].pt, 0, nm);
      recv_blk(0, got, ok);
      chk({nm, " 4 words out"}, 128'(ok), 128'd1);
      exp = tbl[r].model ? aes_enc(tbl[r].key, tbl[r].pt ^ tbl[r-1].ct) : tbl[r].ct;
      chk({nm, " ciphertext"}, got, exp);
      chk({nm, " blk_cnt"}, 128'(blk_cnt), 128'(tbl[r].cnt));
      if (tbl[r].model) chk({nm, " cbc block differs"}, 128'(got != C0), 128'd1);
    end

    // key_load with a partial block is ignored
    key_ld(FK, 128'h0, 1'b0, 1'b0, "partial");
    send_word(P0[127:96], "partial");
    send_word(P0[95:64], "partial");
    key_in = KB; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    kr = 0;
    for (int i = 0; i < 4; i++) begin
      if (core_krdy) kr++;
      tick();
    end
    chk("partial key unchanged",  core_key, FK);
    chk("partial key_valid kept", 128'(key_valid), 128'd1);
    chk("partial no krdy",        128'(kr), 128'd0);
    send_word(P0[63:32], "partial");
    send_word(P0[31:0], "partial");
    recv_blk(0, got, ok);
    chk("partial ciphertext", got, C0);

    // key_load with a simultaneous word at count 0: key wins, word dropped
    key_ld(KB, 128'h0, 1'b0, 1'b1, "simul");
    send_blk(P1, 0, "simul");
    recv_blk(0, got, ok);
    chk("simul ciphertext", got, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

    // Backpressure on both sides
    send_blk(P2, 2, "bp");
    recv_blk(1, got, ok);
    chk("bp 4 words out",   128'(ok), 128'd1);
    chk("bp ciphertext",    got, 128'hf5d3d58503b9699de785895a96fdbaaf);
    chk("bp m_data stable", 128'(stab_err), 128'd0);
    repeat (3) tick();
    chk("bp m_valid idle",  128'(m_valid), 128'd0);
    chk("drdy after 4th word", 128'(drdy_early), 128'd0);

    // Busy then watchdog timeout
    stub_dead = 1'b1;
    core_bsy  = 1'b1;
    send_blk(P0, 0, "busy");
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (core_drdy) flag = 1'b1;
      tick();
    end
    chk("busy no drdy", 128'(flag), 128'd0);
    core_bsy = 1'b0;
    tick();
    chk("busy drdy after release", 128'(core_drdy), 128'd1);
    k = 0;
    while (!err && k < TO + 10) begin
      tick();
      k++;
    end
    chk("timeout err delay", 128'(k), 128'(TO));
    chk("timeout s_ready",   128'(s_ready), 128'd1);
    chk("timeout m_valid",   128'(m_valid), 128'd0);
    stub_dead = 1'b0;
    key_ld(FK, 128'h0, 1'b0, 1'b0, "reload");
    chk("reload clears err", 128'(err), 128'd0);

    // Reset during WAIT, late core_dvld
    stub_lat = 12;
    send_blk(P0, 0, "mrst");
    flag = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (core_drdy) begin flag = 1'b1; break; end
      tick();
    end
    chk("mrst drdy seen", 128'(flag), 128'd1);
    repeat (2) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst s_ready",    128'(s_ready),    128'd0);
    chk("mrst m_valid",    128'(m_valid),    128'd0);
    chk("mrst m_data",     128'(m_data),     128'd0);
    chk("mrst core_krdy",  128'(core_krdy),  128'd0);
    chk("mrst core_drdy",  128'(core_drdy),  128'd0);
    chk("mrst core_en",    128'(core_en),    128'd0);
    chk("mrst core_rst_n", 128'(core_rst_n), 128'd0);
    chk("mrst core_key",   core_key,         128'd0);
    chk("mrst core_din",   core_din,         128'd0);
    chk("mrst key_valid",  128'(key_valid),  128'd0);
    chk("mrst err",        128'(err),        128'd0);
    chk("mrst blk_cnt",    128'(blk_cnt),    128'd0);
    tick();
    chk("mrst core_rst_n release", 128'(core_rst_n), 128'd1);
    flag = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid) flag = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    chk("mrst late dvld ignored", 128'(flag), 128'd0);
    chk("mrst blk_cnt stays",     128'(blk_cnt), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
